// File: rtl/argmax.sv
// -----------------------------------------------------------------------------
// argmax
//   Final classifier stage. Consumes one signed logit per beat, where the class
//   index is the beat's position in the frame. At the end of each frame it emits
//   a one-hot vector that marks the class with the largest logit. On a tie the
//   lowest class index wins. Bit 0 is the wake-word class.
//
// Ports
//   clk_i    in   clock
//   rst_n_i  in   synchronous active-low reset
//   data_i   in   [I_BW-1:0] signed logit for the current class
//   valid_i  in   data_i valid
//   last_i   in   final beat of the logit frame
//   ready_o  out  a beat is accepted this cycle when valid_i is also high
//   data_o   out  [NUM_CLASSES-1:0] one-hot argmax, zero when no result is held
//   valid_o  out  data_o valid
//   last_o   out  end of output frame; equals valid_o (one beat per frame)
//   ready_i  in   downstream accepts data_o
//   err_o    out  sticky flag: a frame length mismatch was seen since reset
// -----------------------------------------------------------------------------
module argmax #(
    parameter int NUM_CLASSES = 3,
    parameter int I_BW        = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [I_BW-1:0]        data_i,
    input  logic                   valid_i,
    input  logic                   last_i,
    output logic                   ready_o,
    output logic [NUM_CLASSES-1:0] data_o,
    output logic                   valid_o,
    output logic                   last_o,
    input  logic                   ready_i,
    output logic                   err_o
);

    localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic {
        S_ACCUM  = 1'b0,
        S_OUTPUT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        r_arg;
    logic signed [I_BW-1:0]  r_max;
    logic [NUM_CLASSES-1:0]  r_data;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_first;
    logic                    w_greater;
    logic                    w_at_last_idx;
    logic                    w_frame_end;
    logic                    w_mismatch;
    logic                    w_handshake;
    logic [IDX_W-1:0]        w_arg_next;

    assign w_accept      = valid_i && (r_state == S_ACCUM);
    assign w_handshake   = ready_i && (r_state == S_OUTPUT);
    assign w_first       = (r_idx == '0);
    // Strict compare: an equal logit never displaces the earlier class.
    assign w_greater     = $signed(data_i) > r_max;
    assign w_at_last_idx = (r_idx == LAST_IDX);
    assign w_frame_end   = last_i || w_at_last_idx;
    // The frame is well formed only when last_i lands exactly on the final class.
    assign w_mismatch    = (last_i != w_at_last_idx);
    // The ending beat's compare is folded in here, so the one-hot result can be
    // registered on the same edge that accepts the final beat.
    assign w_arg_next    = w_first ? '0 : (w_greater ? r_idx : r_arg);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_ACCUM:  if (w_accept && w_frame_end) w_state_next = S_OUTPUT;
            S_OUTPUT: if (w_handshake)             w_state_next = S_ACCUM;
            default:                               w_state_next = S_ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= S_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_idx  <= '0;
            r_arg  <= '0;
            r_max  <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_first || w_greater) begin
                    r_max <= data_i;
                end
                r_arg <= w_arg_next;
                if (w_frame_end) begin
                    r_idx  <= '0;
                    r_data <= NUM_CLASSES'(1) << w_arg_next;
                    if (w_mismatch) begin
                        r_err <= 1'b1;
                    end
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            // data_o reads zero whenever no result is being offered.
            if (w_handshake) begin
                r_data <= '0;
            end
        end
    end

    assign ready_o = (r_state == S_ACCUM);
    assign valid_o = (r_state == S_OUTPUT);
    assign last_o  = (r_state == S_OUTPUT);
    assign data_o  = r_data;
    assign err_o   = r_err;

endmodule

// File: tb/tb_argmax.sv
// -----------------------------------------------------------------------------
// tb_argmax
//   Self-checking bench for argmax (NUM_CLASSES=3, I_BW=32). A frame-level
//   reference model collects each frame's logits in a queue and picks the first
//   maximum. A compare process checks every DUT output against it on every
//   falling edge. Directed frames also pin literal one-hot results, and a
//   randomized phase follows.
// -----------------------------------------------------------------------------
module tb_argmax;

    localparam int NC = 3;
    localparam int BW = 32;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic [BW-1:0] data_i;
    logic          valid_i;
    logic          last_i;
    logic          ready_o;
    logic [NC-1:0] data_o;
    logic          valid_o;
    logic          last_o;
    logic          ready_i;
    logic          err_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    argmax #(.NUM_CLASSES(NC), .I_BW(BW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .ready_i (ready_i),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic signed [BW-1:0] q[$];
    logic                 m_valid;
    logic [NC-1:0]        m_onehot;
    logic                 m_err;

    always @(posedge clk) begin
        int best;
        if (!rst_n_i) begin
            q.delete();
            m_valid  <= 1'b0;
            m_onehot <= '0;
            m_err    <= 1'b0;
        end else if (m_valid) begin
            if (ready_i) m_valid <= 1'b0;
        end else if (valid_i) begin
            q.push_back(data_i);
            if (last_i || q.size() == NC) begin
                best = 0;
                for (int i = 1; i < q.size(); i++)
                    if (q[i] > q[best]) best = i;
                m_onehot <= NC'(1) << best;
                m_valid  <= 1'b1;
                if (!(last_i && q.size() == NC)) m_err <= 1'b1;
                q.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (started)
            check("outputs{rdy,vld,last,data,err}",
                  {ready_o, valid_o, last_o, data_o, err_o},
                  {~m_valid, m_valid, m_valid, (m_valid ? m_onehot : {NC{1'b0}}), m_err});
    end

    // ---------------- stimulus helpers ----------------
    // Called and returns at 1 ns after a rising edge.
    task automatic send_beat(input logic [BW-1:0] d, input logic l);
        int  n  = 0;
        logic ok = 1'b0;
        data_i  = d;
        last_i  = l;
        valid_i = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
        check("beat_accepted", ok, 1'b1);
    endtask

    task automatic expect_out(input string name, input logic [NC-1:0] exp_d,
                              input logic exp_e, input int budget);
        int n = 0;
        @(negedge clk);
        while (!valid_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, valid_o, 1'b1);
        check({name, "_data"},  data_o,  exp_d);
        check({name, "_err"},   err_o,   exp_e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n_i = 1'b0;
        data_i  = '0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        started = 1'b1;
        @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        @(negedge clk);
        check("reset_state", {ready_o, valid_o, last_o, data_o, err_o}, 7'b1000000);
        @(posedge clk);
        #1;

        // 1: basic frame, result the cycle after the final beat, lasts one cycle
        send_beat(32'd5, 1'b0);
        send_beat(-32'sd3, 1'b0);
        send_beat(32'd2, 1'b1);
        expect_out("t1", 3'b001, 1'b0, 0);
        @(negedge clk);
        check("t1_single_cycle", valid_o, 1'b0);
        @(posedge clk);
        #1;

        // 2: signed compare
        send_beat(-32'sd7, 1'b0);
        send_beat(-32'sd2, 1'b0);
        send_beat(-32'sd9, 1'b1);
        expect_out("t2a", 3'b010, 1'b0, 0);
        send_beat(32'h7FFF_FFFF, 1'b0);
        send_beat(32'h8000_0000, 1'b0);
        send_beat(32'h0, 1'b1);
        expect_out("t2b", 3'b001, 1'b0, 0);

        // 3: ties keep the lowest index
        send_beat(32'd4, 1'b0);
        send_beat(32'd4, 1'b0);
        send_beat(32'd1, 1'b1);
        expect_out("t3a", 3'b001, 1'b0, 0);
        send_beat(32'd1, 1'b0);
        send_beat(32'd9, 1'b0);
        send_beat(32'd9, 1'b1);
        expect_out("t3b", 3'b010, 1'b0, 0);

        // 4: backpressure with extra beats offered while the result is held
        ready_i = 1'b0;
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b0);
        send_beat(32'd8, 1'b1);
        valid_i = 1'b1;
        data_i  = 32'd99;
        repeat (10) begin
            @(negedge clk);
            check("t4_hold_data", data_o, 3'b100);
            check("t4_hold_ready", ready_o, 1'b0);
        end
        ready_i = 1'b1;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_after_handshake", {ready_o, valid_o}, 2'b10);
        @(posedge clk);
        #1;

        // 5: short frame sets the sticky error; next clean frame keeps it
        send_beat(32'd3, 1'b0);
        send_beat(32'd6, 1'b1);
        expect_out("t5a", 3'b010, 1'b1, 0);
        send_beat(32'd9, 1'b0);
        send_beat(32'd0, 1'b0);
        send_beat(32'd0, 1'b1);
        expect_out("t5b", 3'b001, 1'b1, 0);

        // 6: reset mid-frame discards partial state and the error flag
        send_beat(32'd7, 1'b0);
        send_beat(32'd8, 1'b0);
        rst_n_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        @(negedge clk);
        check("t6_after_reset", {ready_o, valid_o, data_o, err_o}, 6'b100000);
        @(posedge clk);
        #1;
        send_beat(32'd0, 1'b0);
        send_beat(32'd0, 1'b0);
        send_beat(32'd5, 1'b1);
        expect_out("t6", 3'b100, 1'b0, 0);

        // Randomized traffic: small values give frequent ties, plus occasional resets.
        for (int c = 0; c < 2000; c++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0)
                data_i = 32'($signed(int'($urandom_range(0, 4)) - 2));
            else
                data_i = $urandom;
            last_i  = ($urandom_range(0, 3) == 0);
            ready_i = ($urandom_range(0, 3) != 0);
            rst_n_i = ($urandom_range(0, 99) != 0);
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        rst_n_i = 1'b1;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
